// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: RAM command opcodes and arbiter FSM state encoding shared by the arbiter slice.
package ram_arb_pkg;
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; contention goes to the requester not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);
  logic last;
  always_comb grant = (&req) ? (last ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk)
    if (!rst_n) last <= 1'b1;
    else if (update && |grant) last <= grant[1];
endmodule

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: arbitrates two requesters onto a serial RAM command port and returns per-owner responses.
module ram_cmd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RD_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_we,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_we,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp0_valid,
  output logic       rsp0_err,
  output logic [7:0] rsp0_rdata,
  output logic       rsp1_valid,
  output logic       rsp1_err,
  output logic [7:0] rsp1_rdata,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       busy
);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  state_t state, state_nx;
  logic we, owner, accept, wait_done, rsp_fire;
  logic [7:0] addr, wdata;
  logic [CW-1:0] cnt;
  logic [1:0] grant, rsp_valid, rsp_err;
  logic [7:0] rdata [2];
  assign accept = rst_n && state == S_IDLE && (req0_valid || req1_valid);
  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .update (accept),
    .grant  (grant)
  );
  assign req0_ready = accept && grant[0];
  assign req1_ready = accept && grant[1];
  assign wait_done  = state == S_WAIT && (ram_tx_valid || cnt == CW'(RD_TIMEOUT - 1));
  assign rsp_fire   = (state == S_DATA && we) || wait_done;
  assign busy       = state != S_IDLE;
  assign {rsp1_valid, rsp0_valid} = rsp_valid;
  assign {rsp1_err, rsp0_err}     = rsp_err;
  assign rsp0_rdata = rdata[0];
  assign rsp1_rdata = rdata[1];
  always_comb begin
    state_nx = accept ? S_ADDR : state == S_ADDR ? S_DATA : state == S_DATA ? (we ? S_RESP : S_WAIT) :
               wait_done ? S_RESP : state == S_RESP ? S_IDLE : state;
    ram_rx_valid = state == S_ADDR || state == S_DATA;
    ram_din = state == S_ADDR ? {we ? OP_WR_ADDR : OP_RD_ADDR, addr} :
              state == S_DATA ? {we ? OP_WR_DATA : OP_RD_DATA, we ? wdata : 8'h00} : 10'h000;
  end
  // Response fields are registered on RESP entry so they hold between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      we        <= 1'b0;
      owner     <= 1'b0;
      addr      <= 8'h00;
      wdata     <= 8'h00;
      cnt       <= '0;
      rsp_valid <= 2'b00;
      rsp_err   <= 2'b00;
      rdata     <= '{default: 8'h00};
    end else begin
      state     <= state_nx;
      cnt       <= (state == S_WAIT && !wait_done) ? cnt + CW'(1) : '0;
      rsp_valid <= 2'b00;
      if (accept) begin
        owner <= grant[1];
        we    <= grant[1] ? req1_we : req0_we;
        addr  <= grant[1] ? req1_addr : req0_addr;
        wdata <= grant[1] ? req1_wdata : req0_wdata;
      end
      if (rsp_fire) begin
        rsp_valid[owner] <= 1'b1;
        rsp_err[owner]   <= state == S_WAIT && !ram_tx_valid;
        rdata[owner]     <= (state == S_WAIT && ram_tx_valid) ? ram_dout : 8'h00;
      end
    end
  end
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// tb_ram_cmd_arbiter: directed vector table, round-robin sequence and randomized transaction-level model check.
module tb_ram_cmd_arbiter;
  localparam int RT = 4;
  logic clk = 1'b0, rst_n;
  logic req0_valid, req0_ready, req0_we, req1_valid, req1_ready, req1_we;
  logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata, ram_dout;
  logic [9:0] ram_din;
  logic ram_rx_valid, ram_tx_valid, busy;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ram_cmd_arbiter #(.RD_TIMEOUT(RT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err), .rsp1_rdata(rsp1_rdata),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(busy)
  );
  typedef struct {
    logic rst, v0, v1, we;
    logic [7:0] addr, wd;
    logic tx;
    logic [7:0] dout;
    logic [1:0] rdy;
    logic rxv;
    logic [9:0] din;
    logic busy;
    logic [1:0] rspv, err;
    logic [7:0] rd0, rd1;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input int rst, v0, v1, we, addr, wd, tx, dout,
                              input int rdy, rxv, din, bsy, rspv, err, rd0, rd1);
    vec_t r;
    r.rst = rst[0]; r.v0 = v0[0]; r.v1 = v1[0]; r.we = we[0];
    r.addr = addr[7:0]; r.wd = wd[7:0]; r.tx = tx[0]; r.dout = dout[7:0];
    r.rdy = rdy[1:0]; r.rxv = rxv[0]; r.din = din[9:0]; r.busy = bsy[0];
    r.rspv = rspv[1:0]; r.err = err[1:0]; r.rd0 = rd0[7:0]; r.rd1 = rd1[7:0];
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [1:0] rdy, input logic rxv, input logic [9:0] din,
                         input logic bsy, input logic [1:0] rspv, input logic [1:0] err,
                         input logic [7:0] rd0, input logic [7:0] rd1);
    chk({tag, ".ready"}, 32'({req1_ready, req0_ready}), 32'(rdy));
    chk({tag, ".rx_valid"}, 32'(ram_rx_valid), 32'(rxv));
    chk({tag, ".din"}, 32'(ram_din), 32'(din));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), 32'(rspv));
    chk({tag, ".rsp_err"}, 32'({rsp1_err, rsp0_err}), 32'(err));
    chk({tag, ".rdata0"}, 32'(rsp0_rdata), 32'(rd0));
    chk({tag, ".rdata1"}, 32'(rsp1_rdata), 32'(rd1));
  endtask
  task automatic drive(input logic rst, v0, v1, we, input logic [7:0] addr, wd, input logic tx, input logic [7:0] dout);
    rst_n = rst; req0_valid = v0; req1_valid = v1;
    req0_we = we; req1_we = we; req0_addr = addr; req1_addr = addr;
    req0_wdata = wd; req1_wdata = wd; ram_tx_valid = tx; ram_dout = dout;
  endtask
  logic [7:0] mem [256];
  bit pend[2], p_we[2], e_err[2];
  logic [7:0] p_addr[2], p_wd[2], e_rd[2], o_addr, o_wd;
  int free_at, t0, d, rsp_c;
  bit last, owner, o_we, g;
  logic [1:0] e_rdy, e_rspv;
  logic [9:0] e_din;
  logic e_rxv, e_busy;
  initial begin
    tbl.push_back(mk(0,1,1,1,0,0,0,0,        0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,0,0,        0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,1,'h3C,'hA5,0,0,  1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,'h3C,'hA5,0,0,  0,1,'h03C,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,'h3C,'hA5,1,'hFF, 0,1,'h1A5,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,        0,0,0,1,1,0,0,0));
    tbl.push_back(mk(1,0,1,0,'h3C,0,0,0,     2,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,        0,1,'h23C,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,        0,1,'h300,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1,'hA5,     0,0,0,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,        0,0,0,1,2,0,0,'hA5));
    tbl.push_back(mk(1,0,0,0,0,0,1,'h77,     0,0,0,0,0,0,0,'hA5));
    tbl.push_back(mk(1,1,0,0,'h10,0,0,0,     1,0,0,0,0,0,0,'hA5));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,        0,1,'h210,1,0,0,0,'hA5));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,        0,1,'h300,1,0,0,0,'hA5));
    for (int i = 0; i < RT; i++) tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,1,0,0,0,'hA5));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,        0,0,0,1,1,1,0,'hA5));
    tbl.push_back(mk(1,0,0,0,0,0,1,'h99,     0,0,0,0,0,1,0,'hA5));
    tbl.push_back(mk(1,1,0,1,'h55,'h66,0,0,  1,0,0,0,0,1,0,'hA5));
    tbl.push_back(mk(1,0,0,1,'h55,'h66,0,0,  0,1,'h055,1,0,1,0,'hA5));
    tbl.push_back(mk(0,0,0,1,'h55,'h66,0,0,  0,1,'h166,1,0,1,0,'hA5));
    tbl.push_back(mk(1,1,1,1,'h01,'h02,0,0,  1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,1,'h01,'h02,0,0,  0,1,'h001,1,0,0,0,0));
    tbl.push_back(mk(1,0,1,1,'h01,'h02,0,0,  0,1,'h102,1,0,0,0,0));
    tbl.push_back(mk(1,0,1,1,'h01,'h02,0,0,  0,0,0,1,1,0,0,0));
    tbl.push_back(mk(1,0,1,1,'h03,'h04,0,0,  2,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,'h03,'h04,0,0,  0,1,'h003,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,0,0,        0,1,'h104,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,        0,0,0,1,2,0,0,0));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].tx, tbl[i].dout);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].rxv, tbl[i].din, tbl[i].busy,
              tbl[i].rspv, tbl[i].err, tbl[i].rd0, tbl[i].rd1);
      @(posedge clk); #1;
    end
    // Both requesters held valid from reset: grants alternate starting with requester 0.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      int ph, own;
      ph = k % 4; own = (k / 4) % 2;
      drive(1, 1, 1, 1, 8'(k), ~8'(k), 0, 0);
      @(negedge clk);
      chk_all($sformatf("rr%0d", k),
              ph == 0 ? (own == 1 ? 2'b10 : 2'b01) : 2'b00,
              ph == 1 || ph == 2,
              ph == 1 ? {2'b00, 8'(k - 1)} : ph == 2 ? {2'b01, ~8'(k - 2)} : 10'h000,
              ph != 0,
              ph == 3 ? (own == 1 ? 2'b10 : 2'b01) : 2'b00,
              2'b00, 8'h00, 8'h00);
      @(posedge clk); #1;
    end
    // Randomized traffic against a transaction-timing model with a RAM backing store.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    free_at = 0; t0 = -10; rsp_c = -10; d = 0; last = 1'b1; owner = 1'b0; o_we = 1'b0;
    o_addr = 8'h00; o_wd = 8'h00;
    for (int n = 0; n < 2; n++) begin pend[n] = 0; e_err[n] = 0; e_rd[n] = 8'h00; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 2; n++)
        if (!pend[n] && $urandom_range(0, 2) == 0) begin
          pend[n] = 1; p_we[n] = 1'($urandom); p_addr[n] = 8'($urandom_range(0, 7)); p_wd[n] = 8'($urandom);
        end
      rst_n = 1'b1;
      req0_valid = pend[0]; req0_we = p_we[0]; req0_addr = p_addr[0]; req0_wdata = p_wd[0];
      req1_valid = pend[1]; req1_we = p_we[1]; req1_addr = p_addr[1]; req1_wdata = p_wd[1];
      e_rdy = 2'b00;
      if (cyc >= free_at && (pend[0] || pend[1])) begin
        g = (pend[0] && pend[1]) ? !last : pend[1];
        e_rdy[g] = 1'b1; last = g; owner = g; t0 = cyc;
        o_we = p_we[g]; o_addr = p_addr[g]; o_wd = p_wd[g]; pend[g] = 0;
        d = $urandom_range(0, RT + 1);
        rsp_c = o_we ? t0 + 3 : (d < RT ? t0 + 4 + d : t0 + 3 + RT);
        free_at = rsp_c + 1;
        if (o_we) mem[o_addr] = o_wd;
      end
      if (!o_we && cyc >= t0 + 3 && cyc < rsp_c) begin
        ram_tx_valid = d < RT && cyc == t0 + 3 + d;
        ram_dout = ram_tx_valid ? mem[o_addr] : 8'($urandom);
      end else begin
        ram_tx_valid = 1'($urandom);
        ram_dout = 8'($urandom);
      end
      e_rxv = cyc == t0 + 1 || cyc == t0 + 2;
      e_din = cyc == t0 + 1 ? {o_we ? 2'b00 : 2'b10, o_addr} :
              cyc == t0 + 2 ? {o_we ? 2'b01 : 2'b11, o_we ? o_wd : 8'h00} : 10'h000;
      e_busy = cyc > t0 && cyc <= rsp_c;
      e_rspv = 2'b00;
      if (cyc == rsp_c) begin
        e_rspv[owner] = 1'b1;
        e_err[owner] = !o_we && d >= RT;
        e_rd[owner] = (!o_we && d < RT) ? mem[o_addr] : 8'h00;
      end
      @(negedge clk);
      chk_all($sformatf("rnd%0d", cyc), e_rdy, e_rxv, e_din, e_busy, e_rspv,
              {e_err[1], e_err[0]}, e_rd[0], e_rd[1]);
      @(posedge clk); #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
